// File: rtl/imm_extend_arbiter_pkg.sv
// imm_extend_arbiter_pkg: shared widths, requester ids and FSM states
package imm_extend_arbiter_pkg;
    localparam int IMM_W = 10;
    localparam int WORD_W = 18;
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_BR = 1'b1;
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
endpackage

// File: rtl/imm_extend_arbiter_sign_ext.sv
// signExtender10To18bits: combinational sign extension of an immediate
module signExtender10To18bits
    import imm_extend_arbiter_pkg::*;
#(
    parameter int IN_W = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic [IN_W-1:0]  imm,
    output logic [OUT_W-1:0] ext
);
    assign ext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
endmodule

// File: rtl/imm_extend_arbiter.sv
// imm_extend_arbiter: round-robin shared immediate extender with one-entry output register
module imm_extend_arbiter
    import imm_extend_arbiter_pkg::*;
#(
    parameter int IN_W = IMM_W,
    parameter int OUT_W = WORD_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [IN_W-1:0]  req_imm0,
    input  logic [IN_W-1:0]  req_imm1,
    input  logic [1:0]       req_zext,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_id
);
    state_e           state_q, state_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             slot_free, xfer, gid;
    logic [IN_W-1:0]  imm_sel;
    logic [OUT_W-1:0] sext;

    signExtender10To18bits #(.IN_W(IN_W), .OUT_W(OUT_W)) u_sext (
        .imm(imm_sel),
        .ext(sext)
    );

    // arbitration, extension mux and next-state/output-register update
    always_comb begin
        slot_free = (state_q == EMPTY) || out_ready;
        xfer = rst_n && slot_free && (|req_valid);
        gid = (&req_valid) ? ~last_q : (req_valid[1] ? REQ_BR : REQ_ALU);
        req_ready = xfer ? (gid ? 2'b10 : 2'b01) : 2'b00;
        imm_sel = gid ? req_imm1 : req_imm0;
        state_d = state_q;
        data_d = data_q;
        id_d = id_q;
        last_d = last_q;
        if (xfer) begin
            state_d = FULL;
            data_d = {req_zext[gid] ? {(OUT_W-IN_W){1'b0}} : sext[OUT_W-1:IN_W], sext[IN_W-1:0]};
            id_d = gid;
            last_d = gid;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    // state and result registers; reset discards any held result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q <= '0;
            id_q <= REQ_ALU;
            last_q <= REQ_BR;
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            id_q <= id_d;
            last_q <= last_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data = data_q;
    assign out_id = id_q;
endmodule

// File: doc/imm_extend_arbiter.md
# imm_extend_arbiter

Shares one 10-to-18-bit immediate extension unit between two requesters: the ALU immediate path (requester 0) and the branch/jump offset path (requester 1). Arbitrates round-robin, applies sign or zero extension per request, and holds the result in a one-entry output register with a valid/ready handshake. Sits between instruction decode and the 18-bit execute datapath.

## Interface
- `IN_W`, 10, immediate input width
- `OUT_W`, 18, extended output width; must be greater than `IN_W`
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i
- `req_ready`  out  2  per-requester accept; at most one bit high per cycle
- `req_imm0`, `req_imm1`  in  IN_W  immediate for each requester
- `req_zext`  in  2  per-requester mode: 1 selects zero extension, 0 selects sign extension
- `out_valid`  out  1  extended result available
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  OUT_W  extended immediate
- `out_id`  out  1  requester that owns `out_data`

## Operation
- Output slot is free when `!out_valid || out_ready`.
- Grant logic is combinational, from `req_valid`, `last_grant` and slot-free:
  - Slot free and exactly one requester valid: that requester is granted.
  - Slot free and both valid: the requester other than `last_grant` is granted.
  - Slot not free: no grant, and `req_ready` = 2'b00.
- `req_ready[i]` = grant to i. A transfer occurs when `req_valid[i] && req_ready[i]`.
- On a transfer:
  - `out_data` is loaded with the extended immediate. Sign mode replicates `imm[IN_W-1]` into the upper `OUT_W-IN_W` bits. Zero mode fills them with 0.
  - `out_id` is loaded with i, `out_valid` is set to 1, and `last_grant` is loaded with i.
- Consumption without a new transfer (`out_valid && out_ready` and no grant): `out_valid` clears, while `out_data`/`out_id` keep their values.
- Consumption and a transfer in the same cycle: the register is overwritten and `out_valid` stays 1. This sustains full throughput.
- While `out_valid && !out_ready`, `out_data` and `out_id` are held stable.
- Two-state FSM:
  - EMPTY to FULL on a transfer.
  - FULL to EMPTY on consumption with no transfer.
  - FULL to FULL on consumption with a transfer, or on a stall.
  - `out_valid` = (state == FULL).
- Requesters must hold `req_valid`/`req_imm`/`req_zext` stable until accepted. The block does not check this.

## Timing
- Reset, sampled on the rising edge with `rst_n`=0: state EMPTY, `out_valid`=0, `out_data`=0, `out_id`=0, `last_grant`=1 (requester 0 wins the first tie), `req_ready`=2'b00.
- Reset mid-operation: any held result is discarded at that edge with no handshake. `req_ready` stays 0 for every cycle in which `rst_n`=0.
- Latency: an immediate accepted at edge N is visible on `out_data` with `out_valid`=1 after edge N.
- Throughput: one result per cycle while `out_ready`=1.
- Fairness: under continuous dual requests, grants strictly alternate. Worst-case wait is one transfer.
- `req_ready` depends combinationally on `out_ready`. No combinational path exists from `req_imm*` to `out_*`.

## Structure
- Shared package (e.g. `cpu_pkg`) holds `IMM_W`=10, `WORD_W`=18, requester ids `REQ_ALU`=0 and `REQ_BR`=1, and FSM state encodings EMPTY/FULL.
- One sub-module: the existing combinational `signExtender10To18bits`, instantiated once on the muxed immediate. Zero extension is a mux on its upper bits, selected by the granted `req_zext`.
- Arbiter, FSM and output register are in this module.

## Test plan
- Sign extension: reset, then req0 valid with imm 10'h200 and zext 0, `out_ready`=1. Expect req_ready=2'b01, and after the next edge out_data=18'h3FE00, out_id=0, out_valid=1.
- Zero extension: req1 with imm 10'h200 and zext 1. Expect out_data=18'h00200 and out_id=1. A positive sign-mode input 10'h1FF gives 18'h001FF.
- Round-robin: both valid for 4 cycles with `out_ready`=1 (requesters re-present new immediates after each accept). Expect grants 0,1,0,1 and out_id sequence 0,1,0,1 with no bubbles.
- Backpressure: out_valid=1 with out_data=18'h3FFFF, `out_ready`=0 for 3 cycles while both requesters are valid. Expect req_ready=2'b00 and the output stable. When `out_ready` rises, the next grant goes to the requester other than `out_id`, and the load happens in that same cycle.
- Drain: single result held, `out_ready`=1, no requests. Expect out_valid=0 after the edge.
- Reset mid-operation: out_valid=1 and `out_ready`=0, then assert `rst_n`=0 for 1 cycle. Expect out_valid=0, out_data=0 and req_ready=2'b00. After release with both valid, requester 0 is granted first.
